// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: pcop encodings, fetch-sequencer states, U-type opcodes.
// The TRAP state exists only when PC_MISALIGN_TRAP_EN is defined.
package riscv_pkg;

  localparam logic [1:0] PCOP_HOLD = 2'd0;
  localparam logic [1:0] PCOP_INC  = 2'd1;
  localparam logic [1:0] PCOP_ADD  = 2'd2;
  localparam logic [1:0] PCOP_SET  = 2'd3;

  localparam logic [31:0] PC_INC = 32'd4;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
`ifdef PC_MISALIGN_TRAP_EN
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
`else
    ST_EXEC  = 2'd2
`endif
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch/issue/execute bus of pc_fetch. master = the sequencer, slave = memory + decode/execute side.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        exec_done;
  logic [1:0]  pcop;
  logic [31:0] pc_target;
  logic        misalign;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, pc, misalign,
    input  imem_ack, imem_rdata, exec_done, pcop, pc_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, pc, misalign,
    output imem_ack, imem_rdata, exec_done, pcop, pc_target
  );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC mux/adder with misalignment detect.
// PC_MISALIGN_TRAP_EN: report misaligned targets; otherwise bits [1:0] are cleared.
module pc_next_calc
  import riscv_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pcop_i,
  input  logic [31:0] pc_target_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  logic [31:0] raw;

  always_comb begin
    raw = pc_i;
    case (pcop_i)
      PCOP_HOLD: raw = pc_i;
      PCOP_INC:  raw = pc_i + PC_INC;
      PCOP_ADD:  raw = pc_i + pc_target_i;
      default:   raw = {pc_target_i[31:1], 1'b0};
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign next_pc_o  = raw;
  assign misalign_o = |raw[1:0];
`else
  assign next_pc_o  = raw & ~32'h3;
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch.sv
// PC holder and one-at-a-time fetch sequencer: FETCH -> ISSUE -> EXEC -> FETCH.
// PC_MISALIGN_TRAP_EN adds a sticky misalign flag and an absorbing TRAP state.
module pc_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  next_pc;
  logic         calc_mis;
  logic         req;

  pc_next_calc u_calc (
    .pc_i        (pc_q),
    .pcop_i      (bus.pcop),
    .pc_target_i (bus.pc_target),
    .next_pc_o   (next_pc),
    .misalign_o  (calc_mis)
  );

`ifdef PC_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
`ifdef PC_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    req     = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      ST_FETCH: begin
        // Gated by rst_n so the request is low while reset is held.
        req = rst_n;
        if (bus.imem_ack) begin
          inst_d  = bus.imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (bus.exec_done) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (calc_mis) begin
            mis_d   = 1'b1;
            state_d = ST_TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
`else
          pc_d    = next_pc;
          state_d = ST_FETCH;
`endif
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = (state_q == ST_ISSUE);
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.misalign   = mis_q;
`else
  assign bus.misalign   = calc_mis;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch against an arithmetic next-PC model; aware of PC_MISALIGN_TRAP_EN.
module tb_pc_fetch;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n;
  pc_fetch_if bus();

  pc_fetch #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] m_pc;
  bit          m_trap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] op,
                                           input logic [31:0] t);
    logic [31:0] n;
    case (op)
      2'd0:    n = pc;
      2'd1:    n = pc + 32'd4;
      2'd2:    n = pc + t;
      default: n = t & 32'hFFFF_FFFE;
    endcase
`ifndef PC_MISALIGN_TRAP_EN
    n = n & 32'hFFFF_FFFC;
`endif
    return n;
  endfunction

  // Entry: at a negedge with the DUT in FETCH. Exit: at a negedge in EXEC.
  task automatic do_fetch(input int dly, input logic [31:0] word);
    for (int i = 0; i < dly; i++) begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      bus.exec_done  = 1'($urandom_range(0, 1));
      bus.pcop       = 2'($urandom);
      bus.pc_target  = $urandom;
      @(negedge clk);
      chk("wait_req",  bus.imem_req,   1);
      chk("wait_addr", bus.imem_addr,  m_pc);
      chk("wait_vld",  bus.inst_valid, 0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    bus.exec_done  = 1'b0;
    @(negedge clk);
    chk("iss_vld",  bus.inst_valid, 1);
    chk("iss_inst", bus.inst,       word);
    chk("iss_pc",   bus.pc,         m_pc);
    chk("iss_req",  bus.imem_req,   0);
    bus.imem_ack   = 1'($urandom_range(0, 1));
    bus.imem_rdata = $urandom;
    @(negedge clk);
    chk("exec_vld",  bus.inst_valid, 0);
    chk("exec_inst", bus.inst,       word);
  endtask

  // Entry: at a negedge in EXEC. Exit: at a negedge in FETCH (or TRAP).
  task automatic do_exec(input int dly, input logic [1:0] op, input logic [31:0] tgt);
    logic [31:0] nxt;
    for (int i = 0; i < dly; i++) begin
      bus.exec_done = 1'b0;
      bus.imem_ack  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("ew_vld", bus.inst_valid, 0);
      chk("ew_req", bus.imem_req,   0);
      chk("ew_pc",  bus.pc,         m_pc);
    end
    bus.exec_done = 1'b1;
    bus.pcop      = op;
    bus.pc_target = tgt;
    bus.imem_ack  = 1'b0;
    nxt = ref_next(m_pc, op, tgt);
    @(negedge clk);
    bus.exec_done = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    if (nxt[1:0] != 2'b00) m_trap = 1'b1;
    else m_pc = nxt;
`else
    m_pc = nxt;
`endif
    chk("nx_addr", bus.imem_addr, m_pc);
    chk("nx_req",  bus.imem_req,  m_trap ? 0 : 1);
    chk("nx_mis",  bus.misalign,  m_trap ? 1 : 0);
  endtask

  // Asynchronous reset pulse started between edges; ends at a negedge in FETCH.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc",   bus.pc,         RST_PC);
    chk("rst_addr", bus.imem_addr,  RST_PC);
    chk("rst_req",  bus.imem_req,   0);
    chk("rst_vld",  bus.inst_valid, 0);
    chk("rst_inst", bus.inst,       0);
    chk("rst_mis",  bus.misalign,   0);
    m_pc   = RST_PC;
    m_trap = 1'b0;
    bus.imem_ack  = 1'b1;
    bus.exec_done = 1'b1;
    @(negedge clk);
    bus.imem_ack  = 1'b0;
    bus.exec_done = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_req",  bus.imem_req,  1);
    chk("rel_addr", bus.imem_addr, RST_PC);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] tgt;
    rst_n          = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.exec_done  = 1'b0;
    bus.pcop       = '0;
    bus.pc_target  = '0;
    @(negedge clk);
    do_reset();

    // Directed sequence from the plan
    do_fetch(0, 32'h1234_5037);
    do_exec(0, PCOP_INC, 32'h0);
    chk("pc_104", bus.imem_addr, 32'h104);
    do_fetch(1, $urandom);
    do_exec(1, PCOP_SET, 32'h200);
    do_fetch(0, $urandom);
    do_exec(0, PCOP_ADD, 32'hFFFF_FF00);
    chk("wrap_100", bus.imem_addr, 32'h100);
    do_fetch(0, $urandom);
    do_exec(2, PCOP_SET, 32'h0000_0801);
    chk("set_800", bus.imem_addr, 32'h800);
    do_fetch(0, $urandom);
    do_exec(0, PCOP_HOLD, $urandom);
    chk("hold_800", bus.imem_addr, 32'h800);
    do_fetch(3, $urandom);

    // Reset mid-exec, then mid-fetch wait
    do_reset();
    do_fetch(0, $urandom);
    do_exec(0, PCOP_SET, 32'h0000_4000);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    chk("mw_addr", bus.imem_addr, 32'h4000);
    do_reset();

    // Random instructions
    for (int k = 0; k < 40; k++) begin
      op  = 2'($urandom);
      tgt = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
      if (op == PCOP_ADD) tgt = tgt & 32'hFFFF_FFFC;
      if (op == PCOP_SET) tgt = tgt & 32'hFFFF_FFFD;
`endif
      do_fetch($urandom_range(0, 3), $urandom);
      do_exec($urandom_range(0, 2), op, tgt);
    end

    // Misaligned offset
    do_fetch(0, $urandom);
    tgt = m_pc;
    do_exec(0, PCOP_ADD, 32'h2);
`ifdef PC_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack  = 1'b1;
      bus.exec_done = 1'b1;
      @(negedge clk);
      chk("trap_req", bus.imem_req,   0);
      chk("trap_vld", bus.inst_valid, 0);
      chk("trap_mis", bus.misalign,   1);
      chk("trap_pc",  bus.pc,         tgt);
    end
`else
    chk("mis_clr_addr", bus.imem_addr, tgt);
    chk("mis_tied",     bus.misalign,  0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
